// File: rtl/bsg_strobe_monitor.sv
// Checks a periodic strobe against a programmed period; reports lock, early and late strobes.
// Optional: define BSG_STROBE_MONITOR_LAST_PERIOD_EN to register the last measured interval.
`timescale 1ns/1ps
module bsg_strobe_monitor #(
  parameter int width_p           = 16,
  parameter int lock_count_p      = 4,
  parameter int err_count_width_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  input  logic [width_p-1:0]           expected_period_i,
  input  logic                         strobe_i,
  output logic                         locked_o,
  output logic                         err_v_o,
  output logic                         err_early_o,
  output logic                         err_late_o,
  output logic [err_count_width_p-1:0] err_count_o,
  output logic [width_p-1:0]           last_period_o
);

  localparam int match_w = $clog2(lock_count_p + 1);
  localparam logic [match_w-1:0] lock_last = match_w'(lock_count_p - 1);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK, LOCKED} state_e;

  state_e               state;
  logic [width_p-1:0]   cnt;
  logic [width_p-1:0]   exp_r;
  logic [match_w-1:0]   match_cnt;

  logic tracking, hit, early, late;

  // Dropping en_i masks every check, including a strobe in the same cycle.
  assign tracking = en_i && ((state == TRACK) || (state == LOCKED));
  assign hit      = tracking &&  strobe_i && (cnt == exp_r);
  assign early    = tracking &&  strobe_i && (cnt <  exp_r);
  assign late     = tracking && !strobe_i && (cnt == exp_r);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      exp_r       <= '0;
      match_cnt   <= '0;
      locked_o    <= 1'b0;
      err_v_o     <= 1'b0;
      err_early_o <= 1'b0;
      err_late_o  <= 1'b0;
      err_count_o <= '0;
    end else begin
      err_v_o     <= early | late;
      err_early_o <= early;
      err_late_o  <= late;
      if ((early || late) && (err_count_o != '1))
        err_count_o <= err_count_o + err_count_width_p'(1);

      if (!en_i) begin
        state    <= IDLE;
        locked_o <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARMED;
          ARMED: begin
            if (strobe_i) begin
              state     <= TRACK;
              cnt       <= '0;
              match_cnt <= '0;
              exp_r     <= expected_period_i;
            end
          end
          default: begin
            if (hit) begin
              cnt   <= '0;
              exp_r <= expected_period_i;
              if (state == TRACK) begin
                match_cnt <= match_cnt + match_w'(1);
                if (match_cnt == lock_last) begin
                  state    <= LOCKED;
                  locked_o <= 1'b1;
                end
              end
            end else if (early) begin
              // Restart measurement from the early strobe.
              cnt       <= '0;
              exp_r     <= expected_period_i;
              match_cnt <= '0;
              state     <= TRACK;
              locked_o  <= 1'b0;
            end else if (late) begin
              match_cnt <= '0;
              state     <= ARMED;
              locked_o  <= 1'b0;
            end else if (cnt != '1) begin
              cnt <= cnt + width_p'(1);
            end
          end
        endcase
      end
    end
  end

`ifdef BSG_STROBE_MONITOR_LAST_PERIOD_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      last_period_o <= '0;
    else if (hit || early)
      last_period_o <= cnt;
  end
`else
  assign last_period_o = '0;
`endif

endmodule

// File: tb/tb_bsg_strobe_monitor.sv
// Randomized and directed checks of bsg_strobe_monitor against a time-stamp based reference model.
`timescale 1ns/1ps
module tb_bsg_strobe_monitor;
  localparam int W    = 8;
  localparam int L    = 4;
  localparam int EW   = 2;
  localparam int CMAX = (1 << W) - 1;
  localparam int EMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset_i, en_i, strobe_i;
  logic [W-1:0]  expected_period_i, last_period_o;
  logic          locked_o, err_v_o, err_early_o, err_late_o;
  logic [EW-1:0] err_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  bsg_strobe_monitor #(.width_p(W), .lock_count_p(L), .err_count_width_p(EW)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
    .expected_period_i(expected_period_i), .strobe_i(strobe_i),
    .locked_o(locked_o), .err_v_o(err_v_o), .err_early_o(err_early_o),
    .err_late_o(err_late_o), .err_count_o(err_count_o), .last_period_o(last_period_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 off, 1 waiting for first strobe, 2 measuring, 3 locked.
  // Intervals are derived from the time stamp of the last accepted strobe.
  int     m_phase, m_per, m_run, m_errs, m_last;
  longint m_last_t, t;
  bit     m_early, m_late;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, t, act, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_per = 0; m_run = 0; m_errs = 0; m_last = 0;
    m_early = 0; m_late = 0; m_last_t = 0;
  endtask

  task automatic model_step(input bit en, input bit stb, input int ep);
    int gap;
    m_early = 0;
    m_late  = 0;
    if (!en) m_phase = 0;
    else if (m_phase == 0) m_phase = 1;
    else if (m_phase == 1) begin
      if (stb) begin
        m_phase = 2; m_last_t = t; m_per = ep; m_run = 0;
      end
    end else begin
      gap = int'(t - m_last_t - 1);
      if (gap > CMAX) gap = CMAX;
      if (stb && gap <= m_per) begin
`ifdef BSG_STROBE_MONITOR_LAST_PERIOD_EN
        m_last = gap;
`endif
        if (gap < m_per) begin
          m_early = 1; m_run = 0; m_phase = 2;
        end else if (m_phase == 2) begin
          m_run++;
          if (m_run == L) m_phase = 3;
        end
        m_last_t = t;
        m_per    = ep;
      end else if (!stb && gap == m_per) begin
        m_late = 1; m_phase = 1; m_run = 0;
      end
    end
    if ((m_early || m_late) && m_errs < EMAX) m_errs++;
  endtask

  task automatic compare();
    chk("locked", locked_o, (m_phase == 3));
    chk("err_v", err_v_o, (m_early || m_late));
    chk("err_early", err_early_o, m_early);
    chk("err_late", err_late_o, m_late);
    chk("err_count", err_count_o, m_errs);
    chk("last_period", last_period_o, m_last);
  endtask

  task automatic cyc(input bit en, input bit stb, input int ep);
    en_i = en;
    strobe_i = stb;
    expected_period_i = W'(ep);
    @(posedge clk);
    t++;
    model_step(en, stb, ep);
    #1;
    compare();
  endtask

  task automatic gap_strobe(input int idles, input int ep);
    repeat (idles) cyc(1'b1, 1'b0, ep);
    cyc(1'b1, 1'b1, ep);
  endtask

  task automatic async_reset();
    #3;
    reset_i = 1'b1;
    #1;
    chk("arst_locked", locked_o, 0);
    chk("arst_err_v", err_v_o, 0);
    chk("arst_early", err_early_o, 0);
    chk("arst_late", err_late_o, 0);
    chk("arst_count", err_count_o, 0);
    chk("arst_last", last_period_o, 0);
    m_reset();
    en_i = 1'b0;
    strobe_i = 1'b0;
    @(posedge clk);
    t++;
    #1;
    reset_i = 1'b0;
  endtask

  int pulses, cd, ep_r, j;
  bit ren, rstb;

  initial begin
    reset_i = 1'b1; en_i = 1'b0; strobe_i = 1'b0; expected_period_i = '0;
    t = 0;
    m_reset();
    #1;
    chk("reset_locked", locked_o, 0);
    chk("reset_err_v", err_v_o, 0);
    chk("reset_count", err_count_o, 0);
    chk("reset_last", last_period_o, 0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    // Lock: 1 arming strobe plus 4 matches at period 4.
    cyc(1'b1, 1'b0, 3);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b1, 1'b1, 3);
      if (k == 4) chk("lock_not_yet", locked_o, 0);
      if (k == 5) chk("lock_after_5th", locked_o, 1);
      repeat (3) cyc(1'b1, 1'b0, 3);
    end
    chk("lock_no_err", err_count_o, 0);

    // Early strobe while locked.
    cyc(1'b1, 1'b1, 3);
    gap_strobe(1, 3);
    chk("early_v", err_v_o, 1);
    chk("early_q", err_early_o, 1);
    chk("early_late_q", err_late_o, 0);
    chk("early_unlock", locked_o, 0);
    chk("early_count", err_count_o, 1);
    cyc(1'b1, 1'b0, 3);
    chk("early_one_cycle", err_v_o, 0);
    gap_strobe(2, 3);
    repeat (3) gap_strobe(3, 3);
    chk("early_relock", locked_o, 1);

    // Late: withhold the strobe.
    repeat (4) cyc(1'b1, 1'b0, 3);
    chk("late_q", err_late_o, 1);
    chk("late_count", err_count_o, 2);
    chk("late_unlock", locked_o, 0);
    gap_strobe(1, 3);
    repeat (3) gap_strobe(3, 3);
    chk("late_not_yet", locked_o, 0);
    gap_strobe(3, 3);
    chk("late_relock", locked_o, 1);

    // Five early errors saturate the 2-bit counter.
    repeat (5) gap_strobe(1, 3);
    chk("sat_count", err_count_o, 3);
    chk("sat_still_pulses", err_v_o, 1);

    // Maximum period: counter saturates, single late error, no wrap.
    gap_strobe(3, CMAX);
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      cyc(1'b1, 1'b0, CMAX);
      if (err_v_o) pulses++;
    end
    chk("max_period_one_late", pulses, 1);

    // Period 0: strobe held high.
    repeat (6) cyc(1'b1, 1'b1, 0);
    chk("p0_locked", locked_o, 1);
    cyc(1'b1, 1'b0, 0);
    chk("p0_late", err_late_o, 1);

    // Enable drop with simultaneous strobe while locked.
    gap_strobe(0, 3);
    repeat (4) gap_strobe(3, 3);
    chk("en_locked", locked_o, 1);
    repeat (3) cyc(1'b1, 1'b0, 3);
    cyc(1'b0, 1'b1, 3);
    chk("en_drop_unlock", locked_o, 0);
    chk("en_drop_noerr", err_v_o, 0);
    cyc(1'b0, 1'b0, 3);
    chk("en_drop_noerr2", err_v_o, 0);

    // Asynchronous reset mid-interval.
    cyc(1'b1, 1'b0, 3);
    gap_strobe(0, 3);
    repeat (2) cyc(1'b1, 1'b0, 3);
    async_reset();

    // Last period capture: spacing 4 then 3.
    cyc(1'b1, 1'b0, 3);
    gap_strobe(0, 3);
    gap_strobe(3, 3);
`ifdef BSG_STROBE_MONITOR_LAST_PERIOD_EN
    chk("last_match", last_period_o, 3);
`else
    chk("last_off_a", last_period_o, 0);
`endif
    gap_strobe(2, 3);
`ifdef BSG_STROBE_MONITOR_LAST_PERIOD_EN
    chk("last_early", last_period_o, 2);
`else
    chk("last_off_b", last_period_o, 0);
`endif

    // Randomized jittery strobe train.
    cd = 0;
    ep_r = 3;
    for (int k = 0; k < 3000; k++) begin
      ren = ($urandom_range(99) >= 2);
      if ($urandom_range(149) == 0) ep_r = $urandom_range(4);
      rstb = (cd == 0);
      if (rstb) begin
        j = $urandom_range(15);
        cd = ep_r;
        if (j == 0) cd = ep_r + 1;
        else if (j == 1 && ep_r > 0) cd = ep_r - 1;
      end else begin
        cd--;
      end
      cyc(ren, rstb, ep_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
